ram_port_arbiter: RTL and testbench

- Shares the single backing-RAM port (ram_addr/ram_read/ram_write/ram_data_in/ram_data_out) between two requesters.
- Requester 0 is the cache line refill/write-back engine. Requester 1 is a secondary master (loader/debug/DMA).
- Each grant is either a single-word access or a locked, line-aligned burst of WORDS beats.
- Arbitration is round-robin; a granted burst is never preempted.

---
 rtl/ram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one backing-RAM port between two requesters. Requester 0 is the
//   cache refill/write-back engine; requester 1 is a secondary master
//   (loader/debug/DMA). Each grant is either a single word or a locked,
//   line-aligned burst of WORDS beats. Arbitration is round-robin, and a
//   granted burst is never preempted.
//
//   Build option: define ARB_FIXED_PRIO_EN to make requester 0 win every
//   simultaneous request (the round-robin pointer is then removed).
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   reqN/burstN/weN/addrN      request (level), burst select, write, address
//   wdataN                     write data for the beat shown on beat_idx
//   gntN/beatN/rdataN/doneN    owner flag, beat strobe, read data, end pulse
//   beat_idx, busy             current beat number, grant active
//   ram_*                      shared RAM port (ram_data_out is combinational)
module ram_port_arbiter #(
  parameter int WORDS      = 8,
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 9,
  parameter int OFFSET     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  burst0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  beat0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  done0,
  input  logic                  req1,
  input  logic                  burst1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  beat1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  done1,
  output logic [OFFSET:0]       beat_idx,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OFFSET:0]       cnt_q, cnt_d;
`ifndef ARB_FIXED_PRIO_EN
  logic                  rr_q, rr_d;
`endif

  logic                  pick;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic                  last_beat;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    burst_d     = burst_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    beat0       = 1'b0;
    beat1       = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    rdata0      = '0;
    rdata1      = '0;
    beat_idx    = '0;
    busy        = 1'b0;
    ram_addr    = '0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_data_in = '0;
    last_beat   = 1'b0;

`ifdef ARB_FIXED_PRIO_EN
    pick = ~req0;
`else
    // Single requester wins outright; a tie goes to the pointer.
    pick = (req0 & req1) ? rr_q : req1;
`endif
    addr_sel = pick ? addr1 : addr0;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = pick;
          we_d    = pick ? we1 : we0;
          burst_d = pick ? burst1 : burst0;
          // Bursts are line aligned, so the offset bits are dropped.
          base_d  = (pick ? burst1 : burst0)
                    ? {addr_sel[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}}
                    : addr_sel;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy        = 1'b1;
        gnt0        = ~owner_q;
        gnt1        = owner_q;
        beat0       = ~owner_q;
        beat1       = owner_q;
        beat_idx    = cnt_q;
        // Aligned base plus cnt < WORDS never carries out of the line.
        ram_addr    = base_q + ADDR_WIDTH'(cnt_q);
        ram_read    = ~we_q;
        ram_write   = we_q;
        ram_data_in = owner_q ? wdata1 : wdata0;
        if (owner_q) rdata1 = ram_data_out;
        else         rdata0 = ram_data_out;
        cnt_d       = cnt_q + 1'b1;
        last_beat   = burst_q ? (cnt_q == (OFFSET+1)'(WORDS-1)) : 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        done0   = ~owner_q;
        done1   = owner_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_d    = ~owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      base_q  <= '0;
      cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes the expected beats
// and done pulses (with the cycle they must appear on); a monitor pops one
// entry each time the DUT shows a beat or done strobe and compares it.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, burst0, we0, req1, burst1, we1;
  logic [8:0] addr0, addr1;
  logic [5:0] wdata0, wdata1, wbase0, wbase1;
  logic       gnt0, beat0, done0, gnt1, beat1, done1, busy;
  logic [5:0] rdata0, rdata1;
  logic [3:0] beat_idx;
  logic [8:0] ram_addr;
  logic       ram_read, ram_write;
  logic [5:0] ram_data_in, ram_data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .burst0(burst0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .beat0(beat0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .burst1(burst1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .beat1(beat1), .rdata1(rdata1), .done1(done1),
    .beat_idx(beat_idx), .busy(busy),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Owners present beat k's data as base + k.
  assign wdata0 = wbase0 + 6'(beat_idx);
  assign wdata1 = wbase1 + 6'(beat_idx);

  // RAM model: unwritten words hold a fixed address pattern.
  function automatic logic [5:0] rpat(input logic [8:0] a);
    return a[5:0] ^ {a[8:6], a[8:6]};
  endfunction

  bit         written [0:511];
  logic [5:0] wmem    [0:511];
  always @(posedge clk)
    if (ram_write) begin
      written[ram_addr] <= 1'b1;
      wmem[ram_addr]    <= ram_data_in;
    end
  always_comb ram_data_out = written[ram_addr] ? wmem[ram_addr] : rpat(ram_addr);

  typedef struct {
    int         cyc;
    bit         dn;
    bit         who;
    logic [8:0] addr;
    bit         we;
    logic [5:0] din;
    logic [5:0] rd;
    logic [3:0] idx;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int c, input bit who, input logic [8:0] a, input bit we,
                           input logic [5:0] din, input logic [5:0] rd, input int idx);
    exp_t e;
    e.cyc = c; e.dn = 1'b0; e.who = who; e.addr = a; e.we = we;
    e.din = din; e.rd = rd; e.idx = 4'(idx);
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input bit who);
    exp_t e;
    e.cyc = c; e.dn = 1'b1; e.who = who; e.addr = '0; e.we = 1'b0;
    e.din = '0; e.rd = '0; e.idx = '0;
    q.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor
  exp_t       me;
  logic [1:0] moh;
  always @(negedge clk) begin
    if (beat0 | beat1 | done0 | done1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {28'd0, beat1, beat0, done1, done0}, 0);
      end else begin
        me  = q.pop_front();
        moh = me.who ? 2'b10 : 2'b01;
        chk("cycle", cyc, me.cyc);
        if (!me.dn) begin
          chk("beat", {beat1, beat0}, moh);
          chk("gnt", {gnt1, gnt0}, moh);
          chk("done_in_xfer", {done1, done0}, 0);
          chk("busy", busy, 1);
          chk("ram_addr", ram_addr, me.addr);
          chk("ram_read", ram_read, !me.we);
          chk("ram_write", ram_write, me.we);
          chk("beat_idx", beat_idx, me.idx);
          if (me.we) chk("ram_data_in", ram_data_in, me.din);
          else       chk("rdata", me.who ? rdata1 : rdata0, me.rd);
          chk("rdata_other", me.who ? rdata0 : rdata1, 0);
        end else begin
          chk("done", {done1, done0}, moh);
          chk("done_gnt", {gnt1, gnt0}, moh);
          chk("done_beat", {beat1, beat0}, 0);
          chk("done_strobe", {ram_read, ram_write}, 0);
          chk("done_busy", busy, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit w;
    rst = 1'b1;
    req0 = 0; burst0 = 0; we0 = 0; addr0 = '0; wbase0 = '0;
    req1 = 0; burst1 = 0; we1 = 0; addr1 = '0; wbase1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_beat", {beat1, beat0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_strobe", {ram_read, ram_write}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_data_in, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    chk("rst_beat_idx", beat_idx, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_strobe", {ram_read, ram_write}, 0);

    // Requester 0 burst read at 0x05B -> line 0x058..0x05F
    @(posedge clk); #1 k = cyc;
    req0 = 1; burst0 = 1; we0 = 0; addr0 = 9'h05B;
    for (int i = 0; i < 8; i++)
      push_beat(k + 1 + i, 0, 9'h058 + 9'(i), 0, 0, rpat(9'h058 + 9'(i)), i);
    push_done(k + 9, 0);
    @(posedge clk); #1;
    req0 = 0; addr0 = 9'h1FF; we0 = 1; burst0 = 0;  // must be ignored
    drain(30);

    // Requester 1 single write 0x2A -> 0x123
    @(posedge clk); #1 k = cyc;
    req1 = 1; burst1 = 0; we1 = 1; addr1 = 9'h123; wbase1 = 6'h2A;
    push_beat(k + 1, 1, 9'h123, 1, 6'h2A, 0, 0);
    push_done(k + 2, 1);
    @(posedge clk); #1 req1 = 0;
    drain(20);
    chk("mem_123", wmem[9'h123], 6'h2A);

    // Both requesting continuously from reset: 0,1,0,1 (fixed prio: 0,0,0,0)
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; k = cyc;
    req0 = 1; burst0 = 0; we0 = 0; addr0 = 9'h010;
    req1 = 1; burst1 = 0; we1 = 0; addr1 = 9'h020;
    for (int n = 0; n < 4; n++) begin
`ifdef ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = n[0];
`endif
      push_beat(k + 1 + 3*n, w, w ? 9'h020 : 9'h010, 0, 0, rpat(w ? 9'h020 : 9'h010), 0);
      push_done(k + 2 + 3*n, w);
    end
    repeat (10) @(posedge clk);
    #1 req0 = 0; req1 = 0;
    drain(30);

    // Requester 0 burst write at 0x0A3, req dropped after beat 2
    @(posedge clk); #1 k = cyc;
    req0 = 1; burst0 = 1; we0 = 1; addr0 = 9'h0A3; wbase0 = 6'h10;
    for (int i = 0; i < 8; i++)
      push_beat(k + 1 + i, 0, 9'h0A0 + 9'(i), 1, 6'h10 + 6'(i), 0, i);
    push_done(k + 9, 0);
    repeat (4) @(posedge clk);
    #1 req0 = 0;
    drain(30);
    for (int i = 0; i < 8; i++)
      chk("mem_line_0A0", wmem[9'h0A0 + 9'(i)], 6'h10 + 6'(i));

    // Reset at beat 4 of a burst write, then fresh req1 single read
    @(posedge clk); #1 k = cyc;
    req0 = 1; burst0 = 1; we0 = 1; addr0 = 9'h140; wbase0 = 6'h30;
    for (int i = 0; i < 5; i++)
      push_beat(k + 1 + i, 0, 9'h140 + 9'(i), 1, 6'h30 + 6'(i), 0, i);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; req0 = 0;
    @(posedge clk); #1 k = cyc;
    rst = 1'b0;
    req1 = 1; burst1 = 0; we1 = 0; addr1 = 9'h1F7;
    push_beat(k + 1, 1, 9'h1F7, 0, 0, rpat(9'h1F7), 0);
    push_done(k + 2, 1);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ram_write", ram_write, 0);
    chk("abort_gnt", {gnt1, gnt0}, 0);
    @(posedge clk); #1 req1 = 0;
    drain(20);

    repeat (3) @(posedge clk);
    chk("queue_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
